// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants, state enum and funct3 decode for mem_access_ctrl.
// Holds funct3 codes, RAM ram_type codes, exception codes and the FSM state type.
package mem_access_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] RT_NONE = 4'b0000;
    localparam logic [3:0] RT_BYTE = 4'b0001;
    localparam logic [3:0] RT_HALF = 4'b0011;
    localparam logic [3:0] RT_WORD = 4'b1111;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

    // Access width from load funct3; RT_NONE marks an undefined encoding.
    function automatic logic [3:0] f3_to_type(input logic [2:0] f3);
        case (f3)
            LB, LBU: return RT_BYTE;
            LH, LHU: return RT_HALF;
            LW:      return RT_WORD;
            default: return RT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_merge.sv
// mem_load_merge: byte-lane merge and final sign/zero extension for split loads.
// Ports: i_acc assembled bytes, i_byte new byte, i_k lane, i_half (N=2),
//        i_sign extend request; o_merged lane-updated word, o_final extended word.
module mem_load_merge (
    input  logic [31:0] i_acc,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_k,
    input  logic        i_half,
    input  logic        i_sign,
    output logic [31:0] o_merged,
    output logic [31:0] o_final
);

    always_comb begin
        o_merged = i_acc;
        o_merged[8*i_k +: 8] = i_byte;
        o_final = o_merged;
        if (i_half) begin
            o_final[31:16] = {16{i_sign & o_merged[15]}};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer in front of the data RAM.
// Ports: i_req_* request handshake from execute, o_resp_* response to writeback,
//        ram_* / sign / data_reg / i_ram_misaligned to and from the RAM.
// Macro MEM_MISALIGN_SPLIT_EN: split misaligned half/word accesses into bytes.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [2:0]    i_req_funct3,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    input  logic [4:0]    i_req_rd,
    output logic          o_resp_valid,
    input  logic          i_resp_ready,
    output logic [DW-1:0] o_resp_rdata,
    output logic [4:0]    o_resp_rd,
    output logic [1:0]    o_resp_exc,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdat,
    output logic          ram_we,
    output logic          ram_re,
    output logic [3:0]    ram_type,
    output logic          sign,
    input  logic [DW-1:0] data_reg,
    input  logic          i_ram_misaligned
);

`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_uns;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [4:0]    r_rd;
    logic [1:0]    r_exc;
    logic [3:0]    r_type;

    logic          w_acc;
    logic          w_illegal;
    logic          w_misal;
    logic          w_more;
    logic [3:0]    w_type;
    logic [DW-1:0] w_load;

    assign w_acc  = i_req_valid && (r_state == IDLE);
    assign w_type = f3_to_type(i_req_funct3);
    assign w_illegal = i_req_we ? !(i_req_funct3 inside {SB, SH, SW})
                                : (w_type == RT_NONE);
    assign w_misal = ((w_type == RT_HALF) && i_req_addr[0]) ||
                     ((w_type == RT_WORD) && (i_req_addr[1:0] != 2'b00));

`ifdef MEM_MISALIGN_SPLIT_EN
    logic          r_split;
    logic [1:0]    r_k;
    logic [1:0]    r_last;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_final;

    // More byte accesses remain after the current lane.
    assign w_more = r_split && (r_k != r_last);

    mem_load_merge u_merge (
        .i_acc    (r_rdata),
        .i_byte   (data_reg[7:0]),
        .i_k      (r_k),
        .i_half   (r_last == 2'd1),
        .i_sign   (~r_uns),
        .o_merged (w_merged),
        .o_final  (w_final)
    );

    assign w_load = !r_split ? data_reg : (w_more ? w_merged : w_final);
`else
    assign w_more = 1'b0;
    assign w_load = data_reg;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    if (w_illegal || (w_misal && !SPLIT_ON)) w_next = RESP;
                    else                                     w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!r_we)       w_next = CAPTURE;
                else if (w_more) w_next = ACCESS;
                else             w_next = RESP;
            end
            CAPTURE: w_next = w_more ? ACCESS : RESP;
            RESP:    if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM strobes decode from state only, so reset kills them at once.
    always_comb begin
        o_req_ready  = (r_state == IDLE);
        o_resp_valid = (r_state == RESP);
        ram_addr = '0;
        ram_wdat = '0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_type = RT_NONE;
        sign     = 1'b0;
        if (r_state == ACCESS) begin
            ram_we   = r_we;
            ram_re   = !r_we;
            ram_addr = r_addr;
            ram_wdat = r_we ? r_wdata : '0;
            ram_type = r_type;
            sign     = ~r_uns;
`ifdef MEM_MISALIGN_SPLIT_EN
            if (r_split) begin
                ram_addr = r_addr + AW'(r_k);
                ram_wdat = r_we ? {24'b0, r_wdata[8*r_k +: 8]} : '0;
                ram_type = RT_BYTE;
                sign     = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= '0;
            r_exc   <= EXC_NONE;
            r_type  <= RT_NONE;
`ifdef MEM_MISALIGN_SPLIT_EN
            r_split <= 1'b0;
            r_k     <= '0;
            r_last  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_funct3[2];
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_rd    <= i_req_rd;
                r_type  <= w_type;
                r_rdata <= '0;
                if (w_illegal)                     r_exc <= EXC_ILLEGAL;
                else if (w_misal && !SPLIT_ON)     r_exc <= EXC_MISALIGN;
                else                               r_exc <= EXC_NONE;
`ifdef MEM_MISALIGN_SPLIT_EN
                r_split <= w_misal && !w_illegal;
                r_k     <= '0;
                r_last  <= (w_type == RT_HALF) ? 2'd1 : 2'd3;
`endif
            end
            if (r_state == ACCESS) begin
                if (i_ram_misaligned) r_exc <= EXC_MISALIGN;
`ifdef MEM_MISALIGN_SPLIT_EN
                if (r_we && w_more) r_k <= r_k + 2'd1;
`endif
            end
            if (r_state == CAPTURE) begin
                // A RAM misalign flag seen during ACCESS voids the data.
                r_rdata <= (r_exc != EXC_NONE) ? '0 : w_load;
`ifdef MEM_MISALIGN_SPLIT_EN
                if (w_more) r_k <= r_k + 2'd1;
`endif
            end
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_rd    = r_rd;
    assign o_resp_exc   = r_exc;

endmodule
